// File: rtl/assoc_tlb.sv
`default_nettype none
// ============================================================================
// Module   : assoc_tlb
// Purpose  : N-way set-associative TLB with MMU refill and global flush.
//            Optional hit/miss counters when ASSOC_TLB_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module assoc_tlb #(
    parameter int VPN_BITS    = 36,
    parameter int PPN_BITS    = 44,
    parameter int XLEN        = 64,
    parameter int OFFSET_BITS = 12,
    parameter int WAYS        = 4,
    parameter int SETS        = 64,
    parameter int PERM_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 va_valid_i,
    input  logic [XLEN-1:0]      va_i,
    output logic                 pa_valid_o,
    output logic [XLEN-1:0]      pa_o,
    output logic [PERM_BITS-1:0] pte_perm_o,
    input  logic                 flush_i,
    output logic                 req_valid_o,
    output logic [XLEN-1:0]      req_addr_o,
    input  logic                 resp_valid_i,
    input  logic [XLEN-1:0]      resp_addr_i,
    input  logic [PERM_BITS-1:0] resp_perm_bits_i
`ifdef ASSOC_TLB_PERF_EN
    ,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
`endif
);

    localparam int IDX_BITS = $clog2(SETS);
    localparam int TAG_BITS = VPN_BITS - IDX_BITS;
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_MISS_REQ  = 2'd1;
    localparam logic [1:0] ST_MISS_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
    logic [PPN_BITS-1:0]  ppn_q   [SETS][WAYS];
    logic [PERM_BITS-1:0] perm_q  [SETS][WAYS];
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAY_BITS-1:0]  rr_q    [SETS];

    logic [1:0]           state_q;
    logic [XLEN-1:0]      va_q;
    logic                 kill_q;
    logic                 pa_valid_q;
    logic [XLEN-1:0]      pa_q;
    logic [PERM_BITS-1:0] perm_out_q;
    logic                 req_valid_q;
    logic [XLEN-1:0]      req_addr_q;

    logic [IDX_BITS-1:0]  lk_idx;
    logic [TAG_BITS-1:0]  lk_tag;
    logic                 lk_hit;
    logic [WAY_BITS-1:0]  lk_way;
    logic [XLEN-1:0]      lk_pa;
    logic [PERM_BITS-1:0] lk_perm;

    logic [IDX_BITS-1:0]  mi_idx;
    logic [TAG_BITS-1:0]  mi_tag;
    logic                 vic_free;
    logic [WAY_BITS-1:0]  vic_way;
    logic [WAY_BITS-1:0]  rr_next;
    logic                 fill;
    logic [XLEN-1:0]      resp_pa;
    logic                 unused_bits;

    assign lk_idx  = va_i[OFFSET_BITS +: IDX_BITS];
    assign lk_tag  = va_i[OFFSET_BITS + IDX_BITS +: TAG_BITS];
    assign mi_idx  = va_q[OFFSET_BITS +: IDX_BITS];
    assign mi_tag  = va_q[OFFSET_BITS + IDX_BITS +: TAG_BITS];
    assign resp_pa = XLEN'({resp_addr_i[OFFSET_BITS +: PPN_BITS], {OFFSET_BITS{1'b0}}});
    assign unused_bits = ^{va_i, resp_addr_i};

    // Descending scan so the lowest matching way is the one left standing
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_BITS'(w);
            end
        end
        lk_pa   = XLEN'({ppn_q[lk_idx][lk_way], {OFFSET_BITS{1'b0}}});
        lk_perm = perm_q[lk_idx][lk_way];
    end

    always_comb begin
        vic_free = 1'b0;
        vic_way  = rr_q[mi_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[mi_idx][w]) begin
                vic_free = 1'b1;
                vic_way  = WAY_BITS'(w);
            end
        end
        rr_next = (rr_q[mi_idx] == WAY_BITS'(WAYS - 1)) ? '0 : rr_q[mi_idx] + 1'b1;
    end

    assign fill = !reset && (state_q == ST_MISS_WAIT) && resp_valid_i && !flush_i && !kill_q;

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[mi_idx][vic_way]  <= mi_tag;
            ppn_q[mi_idx][vic_way]  <= resp_addr_i[OFFSET_BITS +: PPN_BITS];
            perm_q[mi_idx][vic_way] <= resp_perm_bits_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            va_q        <= '0;
            kill_q      <= 1'b0;
            pa_valid_q  <= 1'b0;
            pa_q        <= '0;
            perm_out_q  <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (flush_i) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (va_valid_i) begin
                        if (lk_hit) begin
                            pa_valid_q <= 1'b1;
                            pa_q       <= lk_pa;
                            perm_out_q <= lk_perm;
                            state_q    <= ST_DONE;
                        end else begin
                            va_q    <= va_i;
                            kill_q  <= 1'b0;
                            state_q <= ST_MISS_REQ;
                        end
                    end
                end
                ST_MISS_REQ: begin
                    req_valid_q <= 1'b1;
                    req_addr_q  <= va_q;
                    if (flush_i) kill_q <= 1'b1;
                    state_q     <= ST_MISS_WAIT;
                end
                ST_MISS_WAIT: begin
                    if (flush_i) kill_q <= 1'b1;
                    if (resp_valid_i) begin
                        req_valid_q <= 1'b0;
                        pa_valid_q  <= 1'b1;
                        pa_q        <= resp_pa;
                        perm_out_q  <= resp_perm_bits_i;
                        state_q     <= ST_DONE;
                        // A flush seen anywhere in the walk means the result is stale for refill
                        if (fill) begin
                            valid_q[mi_idx][vic_way] <= 1'b1;
                            if (!vic_free) rr_q[mi_idx] <= rr_next;
                        end
                    end
                end
                ST_DONE: begin
                    pa_valid_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pa_valid_o  = pa_valid_q;
    assign pa_o        = pa_q;
    assign pte_perm_o  = perm_out_q;
    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_addr_q;

`ifdef ASSOC_TLB_PERF_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if ((state_q == ST_IDLE) && va_valid_i) begin
            if (lk_hit) hit_count_q  <= hit_count_q + 32'd1;
            else        miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_assoc_tlb.sv
`default_nettype none
// ============================================================================
// Module   : tb_assoc_tlb
// Purpose  : Directed table-driven bench for assoc_tlb plus hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_assoc_tlb;

    logic        clk = 1'b0;
    logic        reset;
    logic        va_valid_i;
    logic [63:0] va_i;
    logic        pa_valid_o;
    logic [63:0] pa_o;
    logic [7:0]  pte_perm_o;
    logic        flush_i;
    logic        req_valid_o;
    logic [63:0] req_addr_o;
    logic        resp_valid_i;
    logic [63:0] resp_addr_i;
    logic [7:0]  resp_perm_bits_i;
`ifdef ASSOC_TLB_PERF_EN
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    always #5 clk = ~clk;

    assoc_tlb dut (
        .clk              (clk),
        .reset            (reset),
        .va_valid_i       (va_valid_i),
        .va_i             (va_i),
        .pa_valid_o       (pa_valid_o),
        .pa_o             (pa_o),
        .pte_perm_o       (pte_perm_o),
        .flush_i          (flush_i),
        .req_valid_o      (req_valid_o),
        .req_addr_o       (req_addr_o),
        .resp_valid_i     (resp_valid_i),
        .resp_addr_i      (resp_addr_i),
        .resp_perm_bits_i (resp_perm_bits_i)
`ifdef ASSOC_TLB_PERF_EN
        ,
        .hit_count_o      (hit_count_o),
        .miss_count_o     (miss_count_o)
`endif
    );

    typedef struct {
        logic [63:0] va;
        logic [63:0] rpa;
        logic [7:0]  perm;
        bit          hit;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mask_pa(input logic [63:0] r);
        return {8'h00, r[55:12], 12'h000};
    endfunction

    task automatic check_perf(input string name);
`ifdef ASSOC_TLB_PERF_EN
        check({name, "_hits"}, {32'h0, hit_count_o}, 64'(exp_hits));
        check({name, "_misses"}, {32'h0, miss_count_o}, 64'(exp_misses));
`else
        n_cmp = n_cmp + 0;
`endif
    endtask

    task automatic pulse_flush();
        @(negedge clk) flush_i = 1'b1;
        @(negedge clk) flush_i = 1'b0;
    endtask

    // fmode: 0 none, 1 flush with the lookup, 2 flush with the response, 3 flush in MISS_REQ
    task automatic lookup(input logic [63:0] v, input bit exp_hit, input logic [63:0] rpa,
                          input logic [7:0] perm, input int fmode);
        int waits;
        @(negedge clk);
        va_valid_i = 1'b1;
        va_i       = v;
        flush_i    = (fmode == 1);
        if (exp_hit) exp_hits++; else exp_misses++;
        @(negedge clk);
        flush_i = (fmode == 3);
        check("hit", {63'h0, pa_valid_o}, {63'h0, exp_hit});
        if (pa_valid_o) begin
            check("hit_pa", pa_o, mask_pa(rpa));
            check("hit_perm", {56'h0, pte_perm_o}, {56'h0, perm});
            check("hit_noreq", {63'h0, req_valid_o}, 64'h0);
        end else begin
            waits = 0;
            while (!req_valid_o && waits < 8) begin
                @(negedge clk);
                flush_i = 1'b0;
                waits++;
            end
            check("req_latency", 64'(waits), 64'd1);
            if (req_valid_o) begin
                check("req_addr", req_addr_o, v);
                resp_valid_i     = 1'b1;
                resp_addr_i      = rpa;
                resp_perm_bits_i = perm;
                flush_i          = (fmode == 2);
                @(negedge clk);
                resp_valid_i = 1'b0;
                flush_i      = 1'b0;
                check("miss_pa_valid", {63'h0, pa_valid_o}, 64'h1);
                check("miss_pa", pa_o, mask_pa(rpa));
                check("miss_perm", {56'h0, pte_perm_o}, {56'h0, perm});
                check("req_drop", {63'h0, req_valid_o}, 64'h0);
            end
        end
        va_valid_i = 1'b0;
        @(negedge clk);
        check("pa_pulse", {63'h0, pa_valid_o}, 64'h0);
    endtask

    vec_t tbl[15];

    initial begin
        logic [63:0] va_a, va_b, va_c, va_d;
        reset = 1'b1; va_valid_i = 1'b0; va_i = '0; flush_i = 1'b0;
        resp_valid_i = 1'b0; resp_addr_i = '0; resp_perm_bits_i = '0;

        tbl[0] = '{64'h0000_0000_1234_5000, 64'h0000_0008_0000_3000, 8'h0F, 1'b0};
        tbl[1] = '{64'h0000_0000_1234_5000, 64'h0000_0008_0000_3000, 8'h0F, 1'b1};
        for (int k = 0; k < 5; k++)
            tbl[2 + k] = '{64'h3000 + 64'(k) * 64'h40000, 64'h1_0000_0000 + 64'(k) * 64'h1000,
                           8'(8'h41 + k), 1'b0};
        for (int k = 1; k < 5; k++)
            tbl[6 + k] = '{64'h3000 + 64'(k) * 64'h40000, 64'h1_0000_0000 + 64'(k) * 64'h1000,
                           8'(8'h41 + k), 1'b1};
        tbl[11] = '{64'h3000, 64'h2_0000_5000, 8'hC3, 1'b0};
        tbl[12] = '{64'h0000_FFFF_FFFF_FABC, 64'hFF00_0123_4567_8ABC, 8'hFF, 1'b0};
        tbl[13] = '{64'h0000_FFFF_FFFF_F123, 64'hFF00_0123_4567_8ABC, 8'hFF, 1'b1};
        tbl[14] = '{64'h3000 + 64'h40000, 64'h1_0000_1000, 8'h42, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_pa_valid", {63'h0, pa_valid_o}, 64'h0);
        check("rst_pa", pa_o, 64'h0);
        check("rst_perm", {56'h0, pte_perm_o}, 64'h0);
        check("rst_req_valid", {63'h0, req_valid_o}, 64'h0);
        check("rst_req_addr", req_addr_o, 64'h0);
        check_perf("rst");
        reset = 1'b0;

        for (int i = 0; i < 15; i++)
            lookup(tbl[i].va, tbl[i].hit, tbl[i].rpa, tbl[i].perm, 0);
        check_perf("table");

        va_a = 64'h0000_0000_1234_5000;
        va_b = 64'h3000 + 64'h80000;
        va_c = 64'h0000_0000_0777_7000;
        va_d = 64'h0000_0000_0ABC_D000;

        pulse_flush();
        lookup(va_a, 1'b0, 64'h8_0000_3000, 8'h0F, 0);
        lookup(va_b, 1'b0, 64'h9_0000_4000, 8'h1F, 0);
        lookup(va_a, 1'b1, 64'h8_0000_3000, 8'h0F, 0);
        pulse_flush();
        check_perf("flush_keeps_counts");
        lookup(va_a, 1'b0, 64'h8_0000_3000, 8'h0F, 0);
        lookup(va_b, 1'b0, 64'h9_0000_4000, 8'h1F, 0);

        lookup(va_c, 1'b0, 64'h5_5555_5000, 8'h33, 2);
        lookup(va_c, 1'b0, 64'h5_5555_5000, 8'h33, 3);
        lookup(va_c, 1'b0, 64'h5_5555_5000, 8'h33, 0);
        lookup(va_c, 1'b1, 64'h5_5555_5000, 8'h33, 1);
        lookup(va_c, 1'b0, 64'h5_5555_5000, 8'h33, 0);
        lookup(va_c, 1'b1, 64'h5_5555_5000, 8'h33, 0);
        check_perf("flush_seq");

        // Reset while the walk is outstanding
        @(negedge clk);
        va_valid_i = 1'b1;
        va_i       = va_d;
        repeat (3) @(negedge clk);
        check("walk_pending", {63'h0, req_valid_o}, 64'h1);
        reset      = 1'b1;
        va_valid_i = 1'b0;
        @(negedge clk);
        check("rstwalk_req_valid", {63'h0, req_valid_o}, 64'h0);
        check("rstwalk_pa_valid", {63'h0, pa_valid_o}, 64'h0);
        reset = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        resp_valid_i = 1'b1;
        resp_addr_i  = 64'h7_0000_0000;
        @(negedge clk);
        resp_valid_i = 1'b0;
        check("late_resp_pa_valid", {63'h0, pa_valid_o}, 64'h0);
        @(negedge clk);
        check("late_resp_pa_valid2", {63'h0, pa_valid_o}, 64'h0);
        lookup(va_c, 1'b0, 64'h5_5555_5000, 8'h33, 0);
        lookup(va_a, 1'b0, 64'h8_0000_3000, 8'h0F, 0);
        lookup(va_d, 1'b0, 64'h6_0000_0000, 8'h07, 0);
        lookup(va_d, 1'b1, 64'h6_0000_0000, 8'h07, 0);
        check_perf("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
